exception_sequencer: RTL and testbench

- Multicycle-MIPS exception controller; the driver side of the PC exception mux.
- Detects overflow, invalid-opcode and divide-by-zero events, saves EPC, and fetches the handler address byte from the memory vector table.
- Drives ex_control and pc_write so the PC loads the memory-sourced handler address.
- Stalls the main control unit while sequencing.

---
 rtl/exception_sequencer.sv | 137 +++++++++++++
 tb/tb_exception_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// Multicycle-MIPS exception sequencer: detects exception flags, saves EPC, fetches the
// handler address byte from the memory vector table and steers the PC onto it.
module exception_sequencer #(
  parameter int VEC_OPCODE  = 253,
  parameter int VEC_OVF     = 254,
  parameter int VEC_DIV0    = 255,
  parameter int MEM_LATENCY = 1,
  parameter int EPC_OFFSET  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        invalid_opcode,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_current,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] handler_addr,
  output logic        ex_control,
  output logic        pc_write,
  output logic [1:0]  cause,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_REQ,
    S_WAIT,
    S_LOAD
  } state_t;

  localparam logic [31:0] VEC_OPCODE_W = 32'(VEC_OPCODE);
  localparam logic [31:0] VEC_OVF_W    = 32'(VEC_OVF);
  localparam logic [31:0] VEC_DIV0_W   = 32'(VEC_DIV0);
  localparam logic [31:0] EPC_OFF_W    = 32'(EPC_OFFSET);
  localparam logic [2:0]  CNT_LOAD     = 3'(MEM_LATENCY - 1);

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_DIV0   = 2'd3;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] handler_q, handler_d;

  // Only the low byte of the vector entry is a handler address.
  logic unused_mem_data;
  assign unused_mem_data = ^mem_data[31:8];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cause_q   <= CAUSE_NONE;
      epc_q     <= '0;
      handler_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      handler_q <= handler_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    handler_d = handler_q;
    unique case (state_q)
      S_IDLE: begin
        if (invalid_opcode || overflow || div_zero) begin
          state_d = S_SAVE;
          epc_d   = pc_current - EPC_OFF_W;
          if (invalid_opcode)  cause_d = CAUSE_OPCODE;
          else if (overflow)   cause_d = CAUSE_OVF;
          else                 cause_d = CAUSE_DIV0;
        end
      end
      S_SAVE: state_d = S_REQ;
      S_REQ: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          handler_d = {24'h000000, mem_data[7:0]};
          state_d   = S_LOAD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    epc_write  = 1'b0;
    mem_read   = 1'b0;
    mem_addr   = '0;
    ex_control = 1'b0;
    pc_write   = 1'b0;
    busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_SAVE: epc_write = 1'b1;
      S_REQ, S_WAIT: begin
        mem_read = 1'b1;
        unique case (cause_q)
          CAUSE_OPCODE: mem_addr = VEC_OPCODE_W;
          CAUSE_OVF:    mem_addr = VEC_OVF_W;
          CAUSE_DIV0:   mem_addr = VEC_DIV0_W;
          default:      mem_addr = '0;
        endcase
      end
      S_LOAD: begin
        ex_control = 1'b1;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  assign epc_out      = epc_q;
  assign handler_addr = handler_q;
  assign cause        = cause_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: two instances (memory latency 1 and 3) share stimulus and
// are checked every cycle against a timeline model of the exception sequence.
module tb_exception_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, invalid_opcode, overflow, div_zero;
  logic [31:0] pc_current, mem_data;

  logic [31:0] a_mem_addr, a_epc_out, a_handler_addr;
  logic        a_mem_read, a_epc_write, a_ex_control, a_pc_write, a_busy;
  logic [1:0]  a_cause;
  logic [31:0] b_mem_addr, b_epc_out, b_handler_addr;
  logic        b_mem_read, b_epc_write, b_ex_control, b_pc_write, b_busy;
  logic [1:0]  b_cause;

  exception_sequencer #(.MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .invalid_opcode(invalid_opcode), .overflow(overflow),
    .div_zero(div_zero), .pc_current(pc_current), .mem_data(mem_data),
    .mem_addr(a_mem_addr), .mem_read(a_mem_read), .epc_out(a_epc_out),
    .epc_write(a_epc_write), .handler_addr(a_handler_addr), .ex_control(a_ex_control),
    .pc_write(a_pc_write), .cause(a_cause), .busy(a_busy)
  );

  exception_sequencer #(.MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .invalid_opcode(invalid_opcode), .overflow(overflow),
    .div_zero(div_zero), .pc_current(pc_current), .mem_data(mem_data),
    .mem_addr(b_mem_addr), .mem_read(b_mem_read), .epc_out(b_epc_out),
    .epc_write(b_epc_write), .handler_addr(b_handler_addr), .ex_control(b_ex_control),
    .pc_write(b_pc_write), .cause(b_cause), .busy(b_busy)
  );

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  logic        chk_en       = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Model: t counts cycles since the detect edge (0 = idle). Each output is a fixed
  // window on that timeline: EPC write at 1, memory read 2..2+L, PC load at 3+L.
  int          t_m[2]     = '{0, 0};
  logic [1:0]  cause_m[2] = '{2'd0, 2'd0};
  logic [31:0] epc_m[2]   = '{32'd0, 32'd0};
  logic [31:0] hnd_m[2]   = '{32'd0, 32'd0};

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        t_m[k] = 0; cause_m[k] = 2'd0; epc_m[k] = 32'd0; hnd_m[k] = 32'd0;
      end else if (t_m[k] == 0) begin
        if (invalid_opcode || overflow || div_zero) begin
          t_m[k]     = 1;
          cause_m[k] = invalid_opcode ? 2'd1 : (overflow ? 2'd2 : 2'd3);
          epc_m[k]   = pc_current - 32'd4;
        end
      end else if (t_m[k] == 3 + lat(k)) begin
        t_m[k] = 0;
      end else begin
        if (t_m[k] == 2 + lat(k)) hnd_m[k] = {24'h0, mem_data[7:0]};
        t_m[k]++;
      end
    end
  end

  task automatic compare_dut(input int k, input logic [31:0] maddr, input logic mrd,
                             input logic [31:0] epc, input logic epcw, input logic [31:0] hnd,
                             input logic exc, input logic pcw, input logic [1:0] cs,
                             input logic bsy);
    int   t;
    logic e_mrd, e_pcw;
    string p;
    t     = t_m[k];
    p     = $sformatf("L%0d", lat(k));
    e_mrd = (t >= 2) && (t <= 2 + lat(k));
    e_pcw = (t == 3 + lat(k));
    check_eq({p, ".epc_write"}, 32'(epcw), 32'(t == 1));
    check_eq({p, ".mem_read"}, 32'(mrd), 32'(e_mrd));
    check_eq({p, ".mem_addr"}, maddr, e_mrd ? 32'd252 + 32'(cause_m[k]) : 32'd0);
    check_eq({p, ".pc_write"}, 32'(pcw), 32'(e_pcw));
    check_eq({p, ".ex_control"}, 32'(exc), 32'(e_pcw));
    check_eq({p, ".busy"}, 32'(bsy), 32'(t != 0));
    check_eq({p, ".cause"}, 32'(cs), 32'(cause_m[k]));
    check_eq({p, ".epc_out"}, epc, epc_m[k]);
    check_eq({p, ".handler_addr"}, hnd, hnd_m[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare_dut(0, a_mem_addr, a_mem_read, a_epc_out, a_epc_write, a_handler_addr,
                  a_ex_control, a_pc_write, a_cause, a_busy);
      compare_dut(1, b_mem_addr, b_mem_read, b_epc_out, b_epc_write, b_handler_addr,
                  b_ex_control, b_pc_write, b_cause, b_busy);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int rd_cnt, pcw_at;
    reset = 1'b0; invalid_opcode = 1'b0; overflow = 1'b1; div_zero = 1'b0;
    pc_current = 32'h0000_0040; mem_data = 32'hABCD_0012;

    // Reset held with overflow pending
    @(posedge clk);
    chk_en = 1'b1;
    step(3);
    check_eq("rst.busy", 32'(a_busy), 32'd0);
    check_eq("rst.cause", 32'(b_cause), 32'd0);

    // First edge with reset high detects the overflow
    reset = 1'b1;
    step(1);
    overflow = 1'b0;
    check_eq("ovf.epc_out", a_epc_out, 32'h0000_003C);
    check_eq("ovf.epc_write", 32'(a_epc_write), 32'd1);
    step(1);
    check_eq("ovf.mem_addr0", a_mem_addr, 32'd254);
    step(1);
    check_eq("ovf.mem_addr1", a_mem_addr, 32'd254);
    step(1);
    check_eq("ovf.pc_write", 32'(a_pc_write), 32'd1);
    check_eq("ovf.handler", a_handler_addr, 32'h0000_0012);
    check_eq("ovf.cause", 32'(a_cause), 32'd2);
    step(6);

    // Simultaneous flags: opcode wins, div0 dropped
    invalid_opcode = 1'b1; div_zero = 1'b1; pc_current = 32'h0000_1000;
    step(1);
    invalid_opcode = 1'b0; div_zero = 1'b0;
    check_eq("prio.cause", 32'(a_cause), 32'd1);
    step(1);
    check_eq("prio.mem_addr", a_mem_addr, 32'd253);
    step(10);
    check_eq("prio.idle", 32'(a_busy), 32'd0);

    // Flag raised mid-sequence is ignored
    overflow = 1'b1; mem_data = 32'h1234_5677;
    step(1);
    overflow = 1'b0;
    step(1);
    div_zero = 1'b1;
    step(2);
    div_zero = 1'b0;
    step(8);
    check_eq("ign.idle", 32'(b_busy), 32'd0);

    // Reset during WAIT aborts cleanly, then a full sequence runs
    overflow = 1'b1;
    step(1);
    overflow = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    check_eq("abort.busy", 32'(a_busy), 32'd0);
    check_eq("abort.mem_read", 32'(b_mem_read), 32'd0);
    check_eq("abort.pc_write", 32'(a_pc_write), 32'd0);
    reset = 1'b1; overflow = 1'b1; mem_data = 32'h0000_00A5;
    step(1);
    overflow = 1'b0;
    step(8);

    // Latency-3 instance with wraparound EPC
    div_zero = 1'b1; pc_current = 32'h0000_0002; mem_data = 32'hFFFF_FF3C;
    step(1);
    div_zero = 1'b0;
    check_eq("l3.epc_out", b_epc_out, 32'hFFFF_FFFE);
    rd_cnt = 0; pcw_at = 0;
    for (int i = 2; i <= 10; i++) begin
      step(1);
      if (b_mem_read) rd_cnt++;
      if (b_pc_write) pcw_at = i;
    end
    check_eq("l3.mem_read_cycles", 32'(rd_cnt), 32'd4);
    check_eq("l3.pc_write_at", 32'(pcw_at), 32'd6);
    check_eq("l3.handler", b_handler_addr, 32'h0000_003C);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1);
      reset          = ($urandom_range(0, 99) != 0);
      invalid_opcode = ($urandom_range(0, 9) == 0);
      overflow       = ($urandom_range(0, 9) == 0);
      div_zero       = ($urandom_range(0, 9) == 0);
      pc_current     = $urandom;
      mem_data       = $urandom;
    end
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
